// File: rtl/sram_pkg.sv
// Shared SRAM request definitions used by the arbiter, the read clients and the pixel writer.
package sram_pkg;
  localparam int SRAM_ADDR_W    = 18;
  localparam int SRAM_DATA_W    = 32;
  localparam int SRAM_MASK_W    = 4;
  localparam int SRAM_WREQ_W    = 54;
  localparam int WREQ_DATA_LSB  = 0;
  localparam int WREQ_ADDR_LSB  = 32;
  localparam int WREQ_MASK_LSB  = 50;

  typedef enum logic {WR_IDLE = 1'b0, WR_FILL = 1'b1} wr_state_e;

  function automatic logic [SRAM_WREQ_W-1:0] pack_wreq(input logic [SRAM_MASK_W-1:0] mask,
                                                      input logic [SRAM_ADDR_W-1:0] addr,
                                                      input logic [SRAM_DATA_W-1:0] data);
    logic [SRAM_WREQ_W-1:0] w;
    w = '0;
    w[WREQ_MASK_LSB +: SRAM_MASK_W] = mask;
    w[WREQ_ADDR_LSB +: SRAM_ADDR_W] = addr;
    w[WREQ_DATA_LSB +: SRAM_DATA_W] = data;
    return w;
  endfunction
endpackage

// File: rtl/sram_byte_packer.sv
// Gathers pixels into little-endian byte lanes; presents the finished word (including the
// completing pixel) combinationally so the caller can load it in the same cycle.
module sram_byte_packer
  import sram_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pix_fire,
  input  logic [7:0]             pix_data,
  input  logic                   pix_last,
  output logic                   word_done,
  output logic                   word_last,
  output logic [SRAM_DATA_W-1:0] word_data,
  output logic [SRAM_MASK_W-1:0] word_mask
);
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [SRAM_DATA_W-1:0] pack_q, pack_d;

  always_comb begin
    word_done  = pix_fire & ((byte_cnt_q == 2'd3) | pix_last);
    word_last  = pix_fire & pix_last;
    word_data  = pack_q | (SRAM_DATA_W'(pix_data) << {byte_cnt_q, 3'b000});
    // lanes 0..byte_cnt are filled: 1->0001, 2->0011, 3->0111, 4->1111
    word_mask  = SRAM_MASK_W'((5'd2 << byte_cnt_q) - 5'd1);
    pack_d     = pack_q;
    byte_cnt_d = byte_cnt_q;
    if (word_done) begin
      pack_d     = '0;
      byte_cnt_d = 2'd0;
    end else if (pix_fire) begin
      pack_d     = word_data;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pack_q     <= '0;
      byte_cnt_q <= 2'd0;
    end else begin
      pack_q     <= pack_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end
endmodule

// File: rtl/sram_pixel_writer.sv
// Pixel stream -> SRAM write requests: output register, frame address/word counters and
// frame status flags around the byte packer.
module sram_pixel_writer
  import sram_pkg::*;
#(
  parameter logic [SRAM_ADDR_W-1:0] BASE_ADDR   = 18'h00000,
  parameter int                     FRAME_WORDS = 76800
)(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [7:0]             pix_data,
  input  logic                   pix_last,
  output logic                   w_din_valid,
  input  logic                   w_din_ready,
  output logic [SRAM_WREQ_W-1:0] w_din,
  output logic                   frame_done,
  output logic                   frame_overrun
);
  localparam logic [SRAM_ADDR_W-1:0] LAST_WORD = SRAM_ADDR_W'(FRAME_WORDS - 1);

  wr_state_e              state_q, state_d;
  logic                   rdy_en_q, rdy_en_d, vld_q, vld_d, last_q, last_d;
  logic                   done_q, done_d, ovr_q, ovr_d;
  logic [SRAM_WREQ_W-1:0] wreq_q, wreq_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d, wcnt_q, wcnt_d, load_addr;
  logic                   pix_fire, out_fire, word_done, word_last;
  logic [SRAM_DATA_W-1:0] word_data;
  logic [SRAM_MASK_W-1:0] word_mask;

  // rdy_en_q keeps pix_ready low while reset is held and for the release cycle
  assign pix_ready = rdy_en_q & (~vld_q | w_din_ready);
  assign pix_fire  = pix_valid & pix_ready;
  assign out_fire  = vld_q & w_din_ready;

  sram_byte_packer u_packer (
    .clock     (clock),
    .reset_n   (reset_n),
    .pix_fire  (pix_fire),
    .pix_data  (pix_data),
    .pix_last  (pix_last),
    .word_done (word_done),
    .word_last (word_last),
    .word_data (word_data),
    .word_mask (word_mask)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= WR_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE: if (pix_fire && !word_last) state_d = WR_FILL;
      WR_FILL: if (word_last)              state_d = WR_IDLE;
    endcase
  end

  // A frame's first word always lands on BASE_ADDR
  always_comb load_addr = (state_q == WR_IDLE) ? BASE_ADDR : addr_q;

  always_comb begin
    rdy_en_d = 1'b1;
    vld_d    = vld_q & ~out_fire;
    wreq_d   = wreq_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wcnt_d   = wcnt_q;
    ovr_d    = ovr_q;
    done_d   = out_fire & last_q;
    if (word_done) begin
      vld_d  = 1'b1;
      wreq_d = pack_wreq(word_mask, load_addr, word_data);
      last_d = word_last;
      if (word_last) begin
        addr_d = BASE_ADDR;
        wcnt_d = '0;
      end else if (wcnt_q == LAST_WORD) begin
        addr_d = BASE_ADDR;
        wcnt_d = '0;
        ovr_d  = 1'b1;
      end else begin
        addr_d = load_addr + 18'd1;
        wcnt_d = wcnt_q + 18'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en_q <= 1'b0;
      vld_q    <= 1'b0;
      wreq_q   <= '0;
      last_q   <= 1'b0;
      addr_q   <= BASE_ADDR;
      wcnt_q   <= '0;
      ovr_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rdy_en_q <= rdy_en_d;
      vld_q    <= vld_d;
      wreq_q   <= wreq_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wcnt_q   <= wcnt_d;
      ovr_q    <= ovr_d;
      done_q   <= done_d;
    end
  end

  assign w_din_valid   = vld_q;
  assign w_din         = wreq_q;
  assign frame_done    = done_q;
  assign frame_overrun = ovr_q;
endmodule

// File: tb/tb_sram_pixel_writer.sv
// Bench for sram_pixel_writer: default instance plus a wrap instance (BASE 3FFFE, 4-word frames),
// a per-cycle frame model, a vector table and directed corner sequences.
module tb_sram_pixel_writer;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic        pix_valid = 1'b0, pix_last = 1'b0, w_din_ready = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        pr_o [2], vld_o [2], fd_o [2], ovr_o [2];
  logic [53:0] din_o [2];
  int          checks = 0, errors = 0;

  always #5 clock = ~clock;

  sram_pixel_writer dut_d (
    .clock(clock), .reset_n(reset_n), .pix_valid(pix_valid), .pix_ready(pr_o[0]),
    .pix_data(pix_data), .pix_last(pix_last), .w_din_valid(vld_o[0]), .w_din_ready(w_din_ready),
    .w_din(din_o[0]), .frame_done(fd_o[0]), .frame_overrun(ovr_o[0]));

  sram_pixel_writer #(.BASE_ADDR(18'h3FFFE), .FRAME_WORDS(4)) dut_w (
    .clock(clock), .reset_n(reset_n), .pix_valid(pix_valid), .pix_ready(pr_o[1]),
    .pix_data(pix_data), .pix_last(pix_last), .w_din_valid(vld_o[1]), .w_din_ready(w_din_ready),
    .w_din(din_o[1]), .frame_done(fd_o[1]), .frame_overrun(ovr_o[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [53:0] wq(input logic [3:0] m, input logic [17:0] a, input logic [31:0] d);
    return {m, a, d};
  endfunction

  function automatic logic [31:0] wd(input int b);
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  function automatic logic [17:0] cfg_base(input int i);
    return (i == 0) ? 18'h00000 : 18'h3FFFE;
  endfunction

  function automatic int cfg_fw(input int i);
    return (i == 0) ? 76800 : 4;
  endfunction

  // Frame model: bytes collect into a word; a word waits in a one-entry slot until taken.
  bit          m_rdy [2], m_full [2], m_last [2], m_fd [2], m_ovr [2];
  logic [53:0] m_word [2];
  logic [17:0] m_addr [2];
  logic [31:0] m_acc [2];
  int          m_wcnt [2], m_nb [2];
  logic [53:0] acc0 [$], acc1 [$];

  initial forever begin
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      bit pr, take;
      if (!reset_n) begin
        chk($sformatf("rst_ready%0d", i), pr_o[i], 0);
        chk($sformatf("rst_valid%0d", i), vld_o[i], 0);
        chk($sformatf("rst_din%0d", i), din_o[i], 0);
        chk($sformatf("rst_done%0d", i), fd_o[i], 0);
        chk($sformatf("rst_ovr%0d", i), ovr_o[i], 0);
        m_rdy[i] = 0; m_full[i] = 0; m_last[i] = 0; m_fd[i] = 0; m_ovr[i] = 0;
        m_addr[i] = cfg_base(i); m_wcnt[i] = 0; m_nb[i] = 0; m_acc[i] = 0; m_word[i] = 0;
      end else begin
        pr = m_rdy[i] && (!m_full[i] || w_din_ready);
        chk($sformatf("mdl_ready%0d", i), pr_o[i], pr);
        chk($sformatf("mdl_valid%0d", i), vld_o[i], m_full[i]);
        if (m_full[i]) chk($sformatf("mdl_din%0d", i), din_o[i], m_word[i]);
        chk($sformatf("mdl_done%0d", i), fd_o[i], m_fd[i]);
        chk($sformatf("mdl_ovr%0d", i), ovr_o[i], m_ovr[i]);
        if (vld_o[i] && w_din_ready) begin
          if (i == 0) acc0.push_back(din_o[i]);
          else        acc1.push_back(din_o[i]);
        end
        take = m_full[i] && w_din_ready;
        m_fd[i] = take && m_last[i];
        if (take) m_full[i] = 0;
        if (pix_valid && pr) begin
          m_acc[i] = m_acc[i] | (32'(pix_data) << (8 * m_nb[i]));
          m_nb[i]++;
          if (m_nb[i] == 4 || pix_last) begin
            m_word[i] = {4'((1 << m_nb[i]) - 1), m_addr[i], m_acc[i]};
            m_full[i] = 1; m_last[i] = pix_last; m_nb[i] = 0; m_acc[i] = 0;
            if (pix_last) begin
              m_addr[i] = cfg_base(i); m_wcnt[i] = 0;
            end else if (m_wcnt[i] == cfg_fw(i) - 1) begin
              m_addr[i] = cfg_base(i); m_wcnt[i] = 0; m_ovr[i] = 1;
            end else begin
              m_addr[i] = m_addr[i] + 18'd1; m_wcnt[i]++;
            end
          end
        end
        m_rdy[i] = 1;
      end
    end
  end

  typedef struct {
    bit rst; bit v; logic [7:0] d; bit last; bit wr;
    bit e_pr; bit e_vld; logic [53:0] e_din; bit e_fd;
  } vec_t;
  vec_t tv [$];

  function automatic vec_t mk(input bit rst, input bit v, input logic [7:0] d, input bit last,
                              input bit wr, input bit pr, input bit vld, input logic [53:0] din,
                              input bit fd);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.last = last; t.wr = wr;
    t.e_pr = pr; t.e_vld = vld; t.e_din = din; t.e_fd = fd;
    return t;
  endfunction

  task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit wr, output bit fire);
    @(posedge clock); #1;
    pix_valid = v; pix_data = d; pix_last = l; w_din_ready = wr;
    @(negedge clock);
    fire = v && pr_o[0];
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 0; pix_valid = 0; pix_last = 0; w_din_ready = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    @(posedge clock);
  endtask

  task automatic send_n(input int n, input int start, input bit wr);
    int got; bit f;
    got = 0;
    for (int g = 0; g < n * 4 + 40 && got < n; g++) begin
      cyc(1, 8'(start + got), 0, wr, f);
      if (f) got++;
    end
    chk("send_n_accepted", got, n);
    cyc(0, 8'h00, 0, wr, f);
  endtask

  initial begin
    bit f;
    int nxt;
    logic [17:0] ea [5];
    ea[0] = 18'h3FFFE; ea[1] = 18'h3FFFF; ea[2] = 18'h00000; ea[3] = 18'h00001; ea[4] = 18'h3FFFE;

    // 8 back-to-back pixels, then a 6-pixel frame with partial last word, then edge frames
    tv.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 54'h0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 54'h0, 0));
    for (int k = 1; k <= 4; k++) tv.push_back(mk(0, 1, 8'(k), 0, 1, 1, 0, 54'h0, 0));
    tv.push_back(mk(0, 1, 8'h05, 0, 1, 1, 1, wq(4'hF, 18'd0, 32'h04030201), 0));
    for (int k = 6; k <= 8; k++) tv.push_back(mk(0, 1, 8'(k), 0, 1, 1, 0, 54'h0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, wq(4'hF, 18'd1, 32'h08070605), 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 54'h0, 0));
    tv.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 54'h0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 54'h0, 0));
    for (int k = 0; k < 4; k++) tv.push_back(mk(0, 1, 8'(8'hA0 + k), 0, 1, 1, 0, 54'h0, 0));
    tv.push_back(mk(0, 1, 8'hA4, 0, 1, 1, 1, wq(4'hF, 18'd0, 32'hA3A2A1A0), 0));
    tv.push_back(mk(0, 1, 8'hA5, 1, 1, 1, 0, 54'h0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, wq(4'b0011, 18'd1, 32'h0000A5A4), 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 54'h0, 1));
    for (int k = 1; k <= 4; k++) tv.push_back(mk(0, 1, 8'(8'h11 * k), 0, 1, 1, 0, 54'h0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, wq(4'hF, 18'd0, 32'h44332211), 0));
    for (int k = 5; k <= 8; k++) tv.push_back(mk(0, 1, 8'(8'h11 * k), k == 8, 1, 1, 0, 54'h0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, wq(4'hF, 18'd1, 32'h88776655), 0));
    tv.push_back(mk(0, 1, 8'h99, 1, 1, 1, 0, 54'h0, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, wq(4'b0001, 18'd0, 32'h00000099), 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 54'h0, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 54'h0, 0));

    repeat (2) @(posedge clock);
    for (int k = 0; k < tv.size(); k++) begin
      @(posedge clock); #1;
      reset_n = !tv[k].rst; pix_valid = tv[k].v; pix_data = tv[k].d;
      pix_last = tv[k].last; w_din_ready = tv[k].wr;
      @(negedge clock);
      chk($sformatf("tv%0d_ready", k), pr_o[0], tv[k].e_pr);
      chk($sformatf("tv%0d_valid", k), vld_o[0], tv[k].e_vld);
      if (tv[k].e_vld || tv[k].rst) chk($sformatf("tv%0d_din", k), din_o[0], tv[k].e_din);
      chk($sformatf("tv%0d_done", k), fd_o[0], tv[k].e_fd);
    end

    // backpressure: one word held, intake stalls, release loses nothing
    do_reset();
    acc0.delete();
    nxt = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1, 8'(8'h10 + nxt), 0, 0, f);
      if (f) nxt++;
    end
    chk("bp_accepted", nxt, 4);
    chk("bp_ready_low", pr_o[0], 0);
    chk("bp_valid_held", vld_o[0], 1);
    chk("bp_din_held", din_o[0], wq(4'hF, 18'd0, 32'h13121110));
    chk("bp_none_taken", acc0.size(), 0);
    for (int c = 0; c < 100 && nxt < 16; c++) begin
      cyc(1, 8'(8'h10 + nxt), 0, 1, f);
      if (f) nxt++;
    end
    repeat (3) cyc(0, 8'h00, 0, 1, f);
    chk("bp_word_count", acc0.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < acc0.size()) chk($sformatf("bp_word%0d", k), acc0[k], wq(4'hF, 18'(k), wd(16 + 4 * k)));

    // address wrap mod 2^18 and overrun on the 4-word instance
    do_reset();
    acc0.delete(); acc1.delete();
    send_n(12, 8'h40, 1);
    cyc(0, 8'h00, 0, 1, f);
    chk("wrap_count3", acc1.size(), 3);
    chk("wrap_no_ovr", ovr_o[1], 0);
    send_n(8, 8'h4C, 1);
    cyc(0, 8'h00, 0, 1, f);
    chk("wrap_count5", acc1.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < acc1.size()) chk($sformatf("wrap_word%0d", k), acc1[k], wq(4'hF, ea[k], wd(8'h40 + 4 * k)));
    chk("ovr_set", ovr_o[1], 1);
    repeat (5) cyc(0, 8'h00, 0, 1, f);
    chk("ovr_sticky", ovr_o[1], 1);
    chk("dflt_no_ovr", ovr_o[0], 0);
    chk("dflt_count", acc0.size(), 5);
    if (acc0.size() == 5) chk("dflt_addr4", acc0[4][49:32], 18'd4);

    // reset with a held request, then with two bytes packed
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      if (pass == 0) for (int c = 0; c < 6; c++) cyc(1, 8'(8'hC0 + c), 0, 0, f);
      else begin
        send_n(4, 8'hB0, 1);
        cyc(1, 8'hE1, 0, 1, f);
        cyc(1, 8'hE2, 0, 1, f);
      end
      @(posedge clock); #1;
      reset_n = 0; pix_valid = 0;
      #1;
      chk($sformatf("arst%0d_ready", pass), pr_o[0], 0);
      chk($sformatf("arst%0d_valid", pass), vld_o[0], 0);
      chk($sformatf("arst%0d_din", pass), din_o[0], 0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1;
      @(posedge clock);
      acc0.delete();
      send_n(4, 8'hD1, 1);
      cyc(0, 8'h00, 0, 1, f);
      chk($sformatf("arst%0d_count", pass), acc0.size(), 1);
      if (acc0.size() > 0) chk($sformatf("arst%0d_word", pass), acc0[0], wq(4'hF, 18'd0, 32'hD4D3D2D1));
    end

    // random traffic against the model, with occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit v;
      if ($urandom_range(0, 599) == 0) do_reset();
      else begin
        v = ($urandom_range(0, 9) < 7);
        cyc(v, 8'($urandom), v && ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 9) < 6) || (c > 2000), f);
      end
    end
    repeat (3) cyc(0, 8'h00, 0, 1, f);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
